gmii_rx: RTL and testbench
==========================

# gmii_rx

Receive-side counterpart of the GMII video transmitter: takes Ethernet frames from the PHY GMII receive pins, filters for our UDP video packets, strips headers, and writes YUV422 pixel pairs plus the per-packet line word into the downstream video FIFO. Every frame is CRC-32 checked, and the result is reported with a single-cycle pulse at end of frame. It sits between the PHY and the receive-side video FIFO/timing regenerator, in the `rx_clk` domain.

## Interface
- `dst_mac`, default `{8'h00,8'h23,8'h45,8'h67,8'h89,8'h02}`: expected destination MAC; the last byte is compared against `dst_mac[7:0] - id`.
- `ip_type`, default `16'h0800`: expected EtherType.
- `ip_prot`, default `8'h11`: expected IP protocol (UDP).
- `udp_dport`, default `16'h3039`: expected UDP destination port.
- `pay_len`, default `11'd1280`: payload bytes after the 2-byte line word; must be even.

Ports:
- `rx_clk` in 1: GMII receive clock; the only clock.
- `sys_rst` in 1: asynchronous, active-high reset.
- `id` in 1: board id; selects the expected destination MAC.
- `rx_dv` in 1: GMII data valid.
- `rx_er` in 1: GMII receive error.
- `rxd` in 8: GMII data.
- `full` in 1: downstream FIFO full.
- `wr_en` out 1: write strobe for one pixel pair.
- `din` out 32: `{line_word[15:0], Y[7:0], C[7:0]}`.
- `frame_ok` out 1: pulse; frame accepted and CRC good.
- `frame_err` out 1: pulse; an accepted frame failed.
- `frame_drop` out 1: pulse; frame filtered out by a header mismatch.
- `err_code` out 2: valid with `frame_err`. 0 = CRC, 1 = length, 2 = `rx_er`, 3 = overflow.

## Operation
- Input stage: `rx_dv`, `rx_er` and `rxd` are registered once. The FSM acts only on the registered copies.
- Frame start: a frame starts only on a registered `rx_dv` rising edge (0→1).
- **IDLE → PRE** on that rising edge.
- **PRE**: accepts one or more `0x55` bytes, then `0xD5` → HDR. Any other byte → DROP.
- **HDR** (42 bytes, index 0–41):
  - Checks dst MAC (bytes 0–5), EtherType (12–13), `0x45` (14), `ip_prot` (23) and `udp_dport` (36–37).
  - Any mismatch → DROP, which pulses `frame_drop` at frame end.
  - Source MAC, IP addresses and checksums are not checked.
- **RESOL**: 2 bytes. `line_word` = {byte0, byte1}; it is held for the whole packet.
- **PAYLOAD**:
  - Even byte index = Y, odd = C.
  - When each C byte is received, `wr_en` pulses with `din = {line_word, Y, C}`, giving `pay_len/2` writes per frame.
  - If `full` is high at a write, that word is not written, the sticky overflow flag is set, and reception continues.
- **FCS**: 4 bytes → TAIL.
- **TAIL**: waits for `rx_dv` low.
  - Any extra byte sets the length error.
  - `rx_dv` low during HDR/RESOL/PAYLOAD/FCS also gives a length error (truncated frame).
- **DROP**: waits for `rx_dv` low → IDLE.
- CRC:
  - IEEE 802.3 CRC-32 runs over every byte from dst MAC through FCS inclusive.
  - The frame is good when the final register equals the residue `32'hC704DD7B`.
- End-of-frame verdict for accepted frames (HDR passed), one pulse only. Error priority: `rx_er` > overflow > length > CRC.
- `rx_er` seen at any point while `rx_dv` is high sets the `rx_er` flag.
- All flags, counters and the CRC register are cleared on entry to PRE.

## Timing
- Reset values: `wr_en=0`, `din=0`, `frame_ok=0`, `frame_err=0`, `frame_drop=0`, `err_code=0`, state IDLE.
- Reset mid-frame: after release, the block ignores the rest of the current frame, because it only restarts on a new `rx_dv` rising edge.
- Pixel latency: a C byte sampled on the pins at edge n gives `wr_en` high in the cycle after edge n+2 (input register plus output register).
- Verdict latency: the first `rx_dv=0` sampled at edge n gives the verdict pulse after edge n+2. The pulse lasts exactly one cycle.
- Back-to-back frames: a minimum 1-cycle `rx_dv` gap must be handled. The verdict pulse of frame k may overlap PRE of frame k+1.
- `wr_en` is never asserted outside PAYLOAD. It is asserted at most once every 2 cycles.

## Structure
- Shared package holds:
  - state encoding (IDLE, PRE, HDR, RESOL, PAYLOAD, FCS, TAIL, DROP);
  - `err_code` constants;
  - header byte offsets (14, 23, 36);
  - the CRC residue constant.
- One sub-module, `crc32_d8`: byte-wide CRC-32 with `init`, `en`, `d[7:0]` and `crc[31:0]`, usable by both directions.

## Test plan
- Good frame, `id=0`, `line_word=16'h02CF`, payload Y=`i`, C=`~i` → 640 writes, `din[31:16]=16'h02CF`, first `din[15:0]=16'h00FF`; then `frame_ok`, no other pulse.
- Same frame with one payload byte flipped → 640 writes, `frame_err` with `err_code=0`.
- Dst MAC last byte `8'h02` with `id=1` → zero writes, `frame_drop` only. UDP port `16'h3038` → same result.
- Frame cut 10 bytes into payload → 5 writes, then `frame_err` with `err_code=1`. An 8-cycle gap and a good frame after it → `frame_ok`.
- `full` held high for 3 write slots mid-payload → 637 writes, then `frame_err` with `err_code=3`.
- `sys_rst` pulsed mid-payload while `rx_dv` stays high → outputs 0 and no writes until `rx_dv` drops. The next good frame → `frame_ok`.

Source files
------------

// File: rtl/gmii_rx_pkg.sv
// Shared definitions for the GMII video receive path: FSM states, error codes,
// header byte offsets and CRC constants.
package gmii_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_HDR,
    ST_RESOL,
    ST_PAYLOAD,
    ST_FCS,
    ST_TAIL,
    ST_DROP
  } state_e;

  typedef enum logic [1:0] {
    ERR_CRC  = 2'd0,
    ERR_LEN  = 2'd1,
    ERR_RXER = 2'd2,
    ERR_OVF  = 2'd3
  } err_e;

  typedef struct packed {
    logic bad;
    err_e code;
  } verdict_t;

  localparam logic [10:0] OFF_ETYPE = 11'd12;
  localparam logic [10:0] OFF_VER   = 11'd14;
  localparam logic [10:0] OFF_PROT  = 11'd23;
  localparam logic [10:0] OFF_DPORT = 11'd36;
  localparam logic [10:0] HDR_LAST  = 11'd41;

  localparam logic [7:0] PRE_BYTE     = 8'h55;
  localparam logic [7:0] SFD_BYTE     = 8'hD5;
  localparam logic [7:0] IPV4_VER_IHL = 8'h45;

  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

  // Error priority: rx_er > overflow > length > CRC.
  function automatic verdict_t eval_verdict(input logic rxer, input logic ovf,
                                            input logic len, input logic crc_ok);
    verdict_t v;
    v.bad = 1'b1;
    if (rxer)      v.code = ERR_RXER;
    else if (ovf)  v.code = ERR_OVF;
    else if (len)  v.code = ERR_LEN;
    else begin
      v.code = ERR_CRC;
      v.bad  = !crc_ok;
    end
    return v;
  endfunction

endpackage

// File: rtl/gmii_rx_crc32_d8.sv
// Byte-wide IEEE 802.3 CRC-32. Register holds the reflected, non-inverted value;
// crc presents it bit-reversed so a good frame reads back as the standard residue.
module crc32_d8
  import gmii_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  d,
  output logic [31:0] crc
);

  logic [31:0] r_q, r_d;

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ CRC_POLY_REFL;
      else             c = c >> 1;
    end
    return c;
  endfunction

  always_comb begin
    r_d = r_q;
    if (init)    r_d = '1;
    else if (en) r_d = crc_byte(r_q, d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= '1;
    else     r_q <= r_d;
  end

  always_comb begin
    crc = '0;
    for (int unsigned i = 0; i < 32; i++) crc[i] = r_q[31 - i];
  end

endmodule

// File: rtl/gmii_rx.sv
// GMII receive path: filters UDP video frames, strips headers and writes
// {line_word, Y, C} pixel pairs to the video FIFO with a per-frame CRC verdict.
module gmii_rx
  import gmii_rx_pkg::*;
#(
  parameter logic [47:0] dst_mac   = {8'h00, 8'h23, 8'h45, 8'h67, 8'h89, 8'h02},
  parameter logic [15:0] ip_type   = 16'h0800,
  parameter logic [7:0]  ip_prot   = 8'h11,
  parameter logic [15:0] udp_dport = 16'h3039,
  parameter logic [10:0] pay_len   = 11'd1280
) (
  input  logic        rx_clk,
  input  logic        sys_rst,
  input  logic        id,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rxd,
  input  logic        full,
  output logic        wr_en,
  output logic [31:0] din,
  output logic        frame_ok,
  output logic        frame_err,
  output logic        frame_drop,
  output logic [1:0]  err_code
);

  logic       rx_dv_q, rx_er_q, dv_prev_q;
  logic [7:0] rxd_q;

  // dv is reset high so a frame still in flight across reset never looks like a new rising edge.
  always_ff @(posedge rx_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rx_dv_q   <= 1'b1;
      dv_prev_q <= 1'b1;
      rx_er_q   <= 1'b0;
      rxd_q     <= '0;
    end else begin
      rx_dv_q   <= rx_dv;
      dv_prev_q <= rx_dv_q;
      rx_er_q   <= rx_er;
      rxd_q     <= rxd;
    end
  end

  state_e      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [15:0] line_q, line_d;
  logic [7:0]  y_q, y_d;
  logic        ovf_q, ovf_d, len_q, len_d, rxerr_q, rxerr_d;
  logic        wr_en_q, wr_en_d, ok_q, ok_d, err_q, err_d, drop_q, drop_d;
  logic [31:0] din_q, din_d;
  err_e        code_q, code_d;

  logic        crc_init, crc_en;
  logic [31:0] crc;

  crc32_d8 u_crc (
    .clk  (rx_clk),
    .rst  (sys_rst),
    .init (crc_init),
    .en   (crc_en),
    .d    (rxd_q),
    .crc  (crc)
  );

  logic [7:0] mac_last;
  logic       hdr_chk;
  logic [7:0] hdr_exp;

  assign mac_last = dst_mac[7:0] - {7'd0, id};

  always_comb begin
    hdr_chk = 1'b1;
    hdr_exp = '0;
    case (cnt_q)
      11'd0:           hdr_exp = dst_mac[47:40];
      11'd1:           hdr_exp = dst_mac[39:32];
      11'd2:           hdr_exp = dst_mac[31:24];
      11'd3:           hdr_exp = dst_mac[23:16];
      11'd4:           hdr_exp = dst_mac[15:8];
      11'd5:           hdr_exp = mac_last;
      OFF_ETYPE:       hdr_exp = ip_type[15:8];
      OFF_ETYPE + 1'b1: hdr_exp = ip_type[7:0];
      OFF_VER:         hdr_exp = IPV4_VER_IHL;
      OFF_PROT:        hdr_exp = ip_prot;
      OFF_DPORT:       hdr_exp = udp_dport[15:8];
      OFF_DPORT + 1'b1: hdr_exp = udp_dport[7:0];
      default:         hdr_chk = 1'b0;
    endcase
  end

  logic     fin, fin_len;
  verdict_t vd;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    line_d   = line_q;
    y_d      = y_q;
    ovf_d    = ovf_q;
    len_d    = len_q;
    rxerr_d  = rxerr_q;
    din_d    = din_q;
    code_d   = code_q;
    wr_en_d  = 1'b0;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    drop_d   = 1'b0;
    crc_init = 1'b0;
    crc_en   = 1'b0;
    fin      = 1'b0;
    fin_len  = 1'b0;
    vd       = '0;

    if (state_q != ST_IDLE && rx_dv_q && rx_er_q) rxerr_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (rx_dv_q && !dv_prev_q) begin
          state_d  = ST_PRE;
          cnt_d    = '0;
          ovf_d    = 1'b0;
          len_d    = 1'b0;
          rxerr_d  = rx_er_q;
          crc_init = 1'b1;
        end
      end
      ST_PRE: begin
        if (!rx_dv_q) begin
          state_d = ST_IDLE;
          drop_d  = 1'b1;
        end else if (rxd_q == SFD_BYTE) begin
          state_d = ST_HDR;
          cnt_d   = '0;
        end else if (rxd_q != PRE_BYTE) begin
          state_d = ST_DROP;
        end
      end
      ST_HDR: begin
        if (!rx_dv_q) begin
          fin     = 1'b1;
          fin_len = 1'b1;
        end else begin
          crc_en = 1'b1;
          if (hdr_chk && rxd_q != hdr_exp) begin
            state_d = ST_DROP;
          end else if (cnt_q == HDR_LAST) begin
            state_d = ST_RESOL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_RESOL: begin
        if (!rx_dv_q) begin
          fin     = 1'b1;
          fin_len = 1'b1;
        end else begin
          crc_en = 1'b1;
          if (cnt_q == '0) begin
            line_d[15:8] = rxd_q;
            cnt_d        = 11'd1;
          end else begin
            line_d[7:0] = rxd_q;
            state_d     = ST_PAYLOAD;
            cnt_d       = '0;
          end
        end
      end
      ST_PAYLOAD: begin
        if (!rx_dv_q) begin
          fin     = 1'b1;
          fin_len = 1'b1;
        end else begin
          crc_en = 1'b1;
          if (!cnt_q[0]) begin
            y_d = rxd_q;
          end else if (full) begin
            ovf_d = 1'b1;
          end else begin
            wr_en_d = 1'b1;
            din_d   = {line_q, y_q, rxd_q};
          end
          if (cnt_q == pay_len - 11'd1) begin
            state_d = ST_FCS;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_FCS: begin
        if (!rx_dv_q) begin
          fin     = 1'b1;
          fin_len = 1'b1;
        end else begin
          crc_en = 1'b1;
          if (cnt_q == 11'd3) state_d = ST_TAIL;
          else                cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_TAIL: begin
        if (!rx_dv_q) begin
          fin     = 1'b1;
          fin_len = len_q;
        end else begin
          len_d = 1'b1;
        end
      end
      ST_DROP: begin
        if (!rx_dv_q) begin
          state_d = ST_IDLE;
          drop_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fin) begin
      vd      = eval_verdict(rxerr_q, ovf_q, fin_len, crc == CRC_RESIDUE);
      state_d = ST_IDLE;
      len_d   = fin_len;
      if (vd.bad) begin
        err_d  = 1'b1;
        code_d = vd.code;
      end else begin
        ok_d = 1'b1;
      end
    end
  end

  always_ff @(posedge rx_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      len_q   <= 1'b0;
      rxerr_q <= 1'b0;
      wr_en_q <= 1'b0;
      din_q   <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
      code_q  <= ERR_CRC;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
      len_q   <= len_d;
      rxerr_q <= rxerr_d;
      wr_en_q <= wr_en_d;
      din_q   <= din_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
      code_q  <= code_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign din        = din_q;
  assign frame_ok   = ok_q;
  assign frame_err  = err_q;
  assign frame_drop = drop_q;
  assign err_code   = code_q;

endmodule

// File: tb/tb_gmii_rx.sv
// Directed bench for gmii_rx: table of frame variants plus back-to-back and
// mid-frame reset sequences.
module tb_gmii_rx;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        id = 1'b0;
  logic        rx_dv = 1'b0;
  logic        rx_er = 1'b0;
  logic [7:0]  rxd = '0;
  logic        full = 1'b0;
  logic        wr_en;
  logic [31:0] din;
  logic        frame_ok, frame_err, frame_drop;
  logic [1:0]  err_code;

  gmii_rx dut (
    .rx_clk     (clk),
    .sys_rst    (sys_rst),
    .id         (id),
    .rx_dv      (rx_dv),
    .rx_er      (rx_er),
    .rxd        (rxd),
    .full       (full),
    .wr_en      (wr_en),
    .din        (din),
    .frame_ok   (frame_ok),
    .frame_err  (frame_err),
    .frame_drop (frame_drop),
    .err_code   (err_code)
  );

  always #4 clk = ~clk;

  typedef struct {
    logic        id;
    logic [7:0]  mac_last;
    logic [15:0] dport;
    int          flip;
    int          cut;
    int          full_lo;
    int          full_hi;
    int          er_at;
    int          rst_at;
    int          gap;
    int          exp_wr;
    int          exp_ok;
    int          exp_err;
    int          exp_drop;
    int          exp_code;
  } vec_t;

  int checks = 0;
  int failures = 0;

  logic [31:0] wr_log[$];
  int ok_cnt = 0, err_cnt = 0, drop_cnt = 0, b2b_cnt = 0;
  logic [1:0] last_code = '0;
  logic prev_wr = 1'b0;

  always @(negedge clk) begin
    if (wr_en) wr_log.push_back(din);
    if (wr_en && prev_wr) b2b_cnt++;
    prev_wr = wr_en;
    if (frame_ok) ok_cnt++;
    if (frame_err) begin
      err_cnt++;
      last_code = err_code;
    end
    if (frame_drop) drop_cnt++;
  end

  int s_wr, s_ok, s_err, s_drop;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic snap();
    s_wr   = wr_log.size();
    s_ok   = ok_cnt;
    s_err  = err_cnt;
    s_drop = drop_cnt;
  endtask

  function automatic logic [31:0] crc_ref(input logic [7:0] q[$], input int from);
    logic [31:0] r;
    r = 32'hFFFFFFFF;
    for (int k = from; k < q.size(); k++) begin
      r = r ^ {24'd0, q[k]};
      for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return ~r;
  endfunction

  task automatic send_frame(input vec_t v);
    logic [7:0]  q[$];
    logic [7:0]  h[42];
    logic [31:0] fcs;
    int n;
    q = {};
    for (int k = 0; k < 7; k++) q.push_back(8'h55);
    q.push_back(8'hD5);
    h = '{8'h00, 8'h23, 8'h45, 8'h67, 8'h89, v.mac_last,
          8'h00, 8'h23, 8'h45, 8'h67, 8'h89, 8'h10,
          8'h08, 8'h00,
          8'h45, 8'h00, 8'h05, 8'h1E, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11, 8'h00, 8'h00,
          8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'h02,
          8'h30, 8'h39, v.dport[15:8], v.dport[7:0], 8'h05, 8'h0A, 8'h00, 8'h00};
    for (int k = 0; k < 42; k++) q.push_back(h[k]);
    q.push_back(8'h02);
    q.push_back(8'hCF);
    for (int j = 0; j < 640; j++) begin
      q.push_back(8'(j));
      q.push_back(~8'(j));
    end
    fcs = crc_ref(q, 8);
    q.push_back(fcs[7:0]);
    q.push_back(fcs[15:8]);
    q.push_back(fcs[23:16]);
    q.push_back(fcs[31:24]);
    if (v.flip >= 0) q[52 + v.flip] = q[52 + v.flip] ^ 8'h01;

    n = (v.cut >= 0) ? v.cut : q.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      id    = v.id;
      rx_dv = 1'b1;
      rxd   = q[i];
      rx_er = (i == v.er_at);
      full  = (i >= v.full_lo) && (i <= v.full_hi);
      if (i == v.rst_at) sys_rst = 1'b1;
      if (v.rst_at >= 0 && i == v.rst_at + 1) begin
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_din", din, 32'd0);
        check("rst_ok", {31'd0, frame_ok}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        check("rst_drop", {31'd0, frame_drop}, 32'd0);
        check("rst_code", {30'd0, err_code}, 32'd0);
      end
      if (v.rst_at >= 0 && i == v.rst_at + 3) begin
        sys_rst = 1'b0;
        snap();
      end
    end
    @(posedge clk);
    #1;
    rx_dv = 1'b0;
    rx_er = 1'b0;
    rxd   = '0;
    full  = 1'b0;
    repeat (v.gap - 1) @(posedge clk);
  endtask

  function automatic vec_t mk(input logic vid, input logic [7:0] ml, input logic [15:0] dp,
                              input int fl, input int ct, input int flo, input int fhi,
                              input int er, input int ew, input int eo, input int ee,
                              input int ed, input int ec);
    vec_t v;
    v.id = vid; v.mac_last = ml; v.dport = dp; v.flip = fl; v.cut = ct;
    v.full_lo = flo; v.full_hi = fhi; v.er_at = er; v.rst_at = -1; v.gap = 8;
    v.exp_wr = ew; v.exp_ok = eo; v.exp_err = ee; v.exp_drop = ed; v.exp_code = ec;
    return v;
  endfunction

  vec_t vecs[9];
  vec_t hv;

  initial begin
    // Frame byte index: 0-7 preamble/SFD, 8-49 header, 50-51 line word, 52+p payload.
    vecs[0] = mk(1'b0, 8'h02, 16'h3039, -1, -1,  -1,  -1,  -1, 640, 1, 0, 0, 0);
    vecs[1] = mk(1'b0, 8'h02, 16'h3039, 10, -1,  -1,  -1,  -1, 640, 0, 1, 0, 0);
    vecs[2] = mk(1'b1, 8'h02, 16'h3039, -1, -1,  -1,  -1,  -1,   0, 0, 0, 1, 0);
    vecs[3] = mk(1'b0, 8'h02, 16'h3038, -1, -1,  -1,  -1,  -1,   0, 0, 0, 1, 0);
    vecs[4] = mk(1'b0, 8'h02, 16'h3039, -1, 62,  -1,  -1,  -1,   5, 0, 1, 0, 1);
    vecs[5] = mk(1'b0, 8'h02, 16'h3039, -1, -1,  -1,  -1,  -1, 640, 1, 0, 0, 0);
    vecs[6] = mk(1'b0, 8'h02, 16'h3039, -1, -1, 154, 158,  -1, 637, 0, 1, 0, 3);
    vecs[7] = mk(1'b0, 8'h02, 16'h3039, -1, -1,  -1,  -1, 102, 640, 0, 1, 0, 2);
    vecs[8] = mk(1'b0, 8'h02, 16'h3039, -1, -1, 154, 158, 102, 637, 0, 1, 0, 2);

    repeat (3) @(posedge clk);
    #1;
    check("reset_wr_en", {31'd0, wr_en}, 32'd0);
    check("reset_din", din, 32'd0);
    check("reset_ok", {31'd0, frame_ok}, 32'd0);
    check("reset_err", {31'd0, frame_err}, 32'd0);
    check("reset_drop", {31'd0, frame_drop}, 32'd0);
    check("reset_code", {30'd0, err_code}, 32'd0);
    sys_rst = 1'b0;
    repeat (4) @(posedge clk);

    for (int t = 0; t < 9; t++) begin
      snap();
      send_frame(vecs[t]);
      check($sformatf("v%0d_writes", t), wr_log.size() - s_wr, vecs[t].exp_wr);
      check($sformatf("v%0d_ok", t), ok_cnt - s_ok, vecs[t].exp_ok);
      check($sformatf("v%0d_err", t), err_cnt - s_err, vecs[t].exp_err);
      check($sformatf("v%0d_drop", t), drop_cnt - s_drop, vecs[t].exp_drop);
      if (vecs[t].exp_err > 0)
        check($sformatf("v%0d_code", t), {30'd0, last_code}, vecs[t].exp_code);
      if (vecs[t].exp_wr > 0 && wr_log.size() > s_wr)
        check($sformatf("v%0d_first_din", t), wr_log[s_wr], 32'h02CF00FF);
      if (vecs[t].exp_wr == 640 && wr_log.size() > 0)
        check($sformatf("v%0d_last_din", t), wr_log[wr_log.size() - 1], 32'h02CF7F80);
    end

    // Back-to-back: single idle cycle between two good frames.
    snap();
    hv = vecs[0];
    hv.gap = 1;
    send_frame(hv);
    send_frame(vecs[0]);
    check("b2b_writes", wr_log.size() - s_wr, 1280);
    check("b2b_ok", ok_cnt - s_ok, 2);
    check("b2b_err", err_cnt - s_err, 0);

    // Reset mid-payload while rx_dv stays high; rest of frame must be ignored.
    hv = vecs[0];
    hv.rst_at = 252;
    send_frame(hv);
    check("rst_tail_writes", wr_log.size() - s_wr, 0);
    check("rst_tail_ok", ok_cnt - s_ok, 0);
    check("rst_tail_err", err_cnt - s_err, 0);
    check("rst_tail_drop", drop_cnt - s_drop, 0);
    snap();
    send_frame(vecs[0]);
    check("post_rst_ok", ok_cnt - s_ok, 1);
    check("post_rst_writes", wr_log.size() - s_wr, 640);

    check("wr_en_spacing", b2b_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
